// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams weight words into one selected neuron memory
//
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN (adds the checksum output)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request to load one neuron memory (honoured in IDLE only)
//   neuron_id in   [7:0] target memory index, sampled with start
//   s_valid   in   s_data carries a weight word
//   s_data    in   [DATA_WIDTH-1:0] weight word
//   s_ready   out  word accepted this cycle (high only while loading)
//   wen       out  write strobe, one cycle after each accepted word
//   wadd      out  [ADDR_WIDTH-1:0] write address
//   win       out  [DATA_WIDTH-1:0] write data
//   wsel      out  [NEURON_COUNT-1:0] one-hot memory select
//   busy      out  a load is in progress
//   done      out  pulse coinciding with the final write
//   err       out  pulse after a start with an out-of-range neuron_id
//   checksum  out  [DATA_WIDTH-1:0] wrapping sum of the words of this load
//                  (only with WEIGHT_LOADER_CHECKSUM_EN)
module weight_loader #(
  parameter int NUM_WEIGHT   = 784,
  parameter int NEURON_COUNT = 30,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              neuron_id,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    wen,
  output logic [ADDR_WIDTH-1:0]   wadd,
  output logic [DATA_WIDTH-1:0]   win,
  output logic [NEURON_COUNT-1:0] wsel,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  hs;
  logic                  last_hs;
  logic                  id_ok;
  logic                  accept;

  assign hs      = s_valid & s_ready;
  assign last_hs = hs && (cnt == LAST_ADDR);
  assign id_ok   = ({24'd0, neuron_id} < NEURON_COUNT);
  assign accept  = (state == IDLE) && start && id_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FLUSH lasts exactly one cycle: it is the cycle in which the registered
  // final write is on the bus, so done is simply "in FLUSH".
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (last_hs) state_nxt = FLUSH;
      end
      FLUSH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wen  <= 1'b0;
      wadd <= '0;
      win  <= '0;
      wsel <= '0;
      err  <= 1'b0;
    end else begin
      wen <= hs;
      err <= (state == IDLE) && start && !id_ok;
      if (hs) begin
        wadd <= cnt;
        win  <= s_data;
        // wrap to 0 after the last word so the counter never leaves the
        // valid address range, even with NUM_WEIGHT == 2**ADDR_WIDTH
        cnt  <= last_hs ? '0 : cnt + 1'b1;
      end
      if (accept) begin
        wsel <= NEURON_COUNT'(1) << neuron_id;
        cnt  <= '0;
      end else if (state == FLUSH) begin
        wsel <= '0;
      end
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         checksum <= '0;
    else if (accept) checksum <= '0;
    else if (hs)     checksum <= checksum + s_data;
  end
`endif

endmodule
